// File: rtl/complex_div.sv
// complex_div: sequential Q3.15 complex divider.
// Multiplies by the conjugate, then divides both parts by |den|^2.
module complex_div #(
  parameter int W    = 18,
  parameter int FRAC = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] I1,
  input  logic signed [W-1:0] Q1,
  input  logic signed [W-1:0] I2,
  input  logic signed [W-1:0] Q2,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] I,
  output logic signed [W-1:0] Q,
  output logic                ovf,
  output logic                dz
);

  localparam int PW = 2 * W;
  localparam int NW = PW + 1;
  localparam int RW = NW + FRAC + 1;
  localparam int QW = W - 1;
  localparam int KW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DIV,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic signed [W-1:0] a_q, a_d, b_q, b_d;
  logic signed [W-1:0] c_q, c_d, d_q, d_d;
  logic [KW-1:0] k_q, k_d;
  logic [RW-1:0] rem_re_q, rem_re_d;
  logic [RW-1:0] rem_im_q, rem_im_d;
  logic [QW-1:0] quo_re_q, quo_re_d;
  logic [QW-1:0] quo_im_q, quo_im_d;
  logic [PW-1:0] den_q, den_d;
  logic sgn_re_q, sgn_re_d, sgn_im_q, sgn_im_d;
  logic ov_re_q, ov_re_d, ov_im_q, ov_im_d;
  logic zero_q, zero_d;
  logic signed [W-1:0] i_q, i_d, q_q, q_d;
  logic ovf_q, ovf_d, dz_q, dz_d, done_q, done_d;

  logic signed [PW-1:0] ax, bx, cx, dx;
  logic signed [PW-1:0] p_ac, p_bd, p_bc, p_ad;
  logic signed [PW-1:0] p_cc, p_dd;
  logic [NW-1:0] n_re, n_im, m_re, m_im;
  logic [PW-1:0] den;
  logic [RW-1:0] dsh;
  logic bit_re, bit_im;

  // Signed magnitude to output word, saturating when flagged.
  function automatic logic [W-1:0] fin_val(
    input logic          s,
    input logic          o,
    input logic [QW-1:0] m
  );
    logic [W-1:0] v;
    v = {1'b0, m};
    if (o)
      return s ? {1'b1, {QW{1'b0}}} : {1'b0, {QW{1'b1}}};
    return s ? (~v + W'(1)) : v;
  endfunction

  // Conjugate products, magnitudes and the shifted divisor.
  always_comb begin
    ax   = {{W{a_q[W-1]}}, a_q};
    bx   = {{W{b_q[W-1]}}, b_q};
    cx   = {{W{c_q[W-1]}}, c_q};
    dx   = {{W{d_q[W-1]}}, d_q};
    p_ac = ax * cx;
    p_bd = bx * dx;
    p_bc = bx * cx;
    p_ad = ax * dx;
    p_cc = cx * cx;
    p_dd = dx * dx;
    n_re = {p_ac[PW-1], p_ac} + {p_bd[PW-1], p_bd};
    n_im = {p_bc[PW-1], p_bc} - {p_ad[PW-1], p_ad};
    m_re = n_re[NW-1] ? (~n_re + NW'(1)) : n_re;
    m_im = n_im[NW-1] ? (~n_im + NW'(1)) : n_im;
    den  = p_cc + p_dd;
    dsh  = RW'(den_q) << k_q;
    bit_re = rem_re_q >= dsh;
    bit_im = rem_im_q >= dsh;
  end

  // Next-state and datapath updates for the four-phase sequence.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    k_d      = k_q;
    rem_re_d = rem_re_q;
    rem_im_d = rem_im_q;
    quo_re_d = quo_re_q;
    quo_im_d = quo_im_q;
    den_d    = den_q;
    sgn_re_d = sgn_re_q;
    sgn_im_d = sgn_im_q;
    ov_re_d  = ov_re_q;
    ov_im_d  = ov_im_q;
    zero_d   = zero_q;
    i_d      = i_q;
    q_d      = q_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = I1;
          b_d     = Q1;
          c_d     = I2;
          d_d     = Q2;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        sgn_re_d = n_re[NW-1];
        sgn_im_d = n_im[NW-1];
        rem_re_d = {1'b0, m_re, {FRAC{1'b0}}};
        rem_im_d = {1'b0, m_im, {FRAC{1'b0}}};
        den_d    = den;
        ov_re_d  = {1'b0, m_re} >= {den, 2'b00};
        ov_im_d  = {1'b0, m_im} >= {den, 2'b00};
        zero_d   = den == '0;
        quo_re_d = '0;
        quo_im_d = '0;
        k_d      = KW'(QW - 1);
        state_d  = DIV;
      end
      DIV: begin
        if (bit_re) rem_re_d = rem_re_q - dsh;
        if (bit_im) rem_im_d = rem_im_q - dsh;
        quo_re_d = {quo_re_q[QW-2:0], bit_re};
        quo_im_d = {quo_im_q[QW-2:0], bit_im};
        if (k_q == '0) state_d = FIN;
        else k_d = k_q - KW'(1);
      end
      FIN: begin
        if (zero_q) begin
          i_d   = '0;
          q_d   = '0;
          ovf_d = 1'b0;
          dz_d  = 1'b1;
        end else begin
          i_d   = fin_val(sgn_re_q, ov_re_q, quo_re_q);
          q_d   = fin_val(sgn_im_q, ov_im_q, quo_im_q);
          ovf_d = ov_re_q | ov_im_q;
          dz_d  = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      k_q      <= '0;
      rem_re_q <= '0;
      rem_im_q <= '0;
      quo_re_q <= '0;
      quo_im_q <= '0;
      den_q    <= '0;
      sgn_re_q <= 1'b0;
      sgn_im_q <= 1'b0;
      ov_re_q  <= 1'b0;
      ov_im_q  <= 1'b0;
      zero_q   <= 1'b0;
      i_q      <= '0;
      q_q      <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      k_q      <= k_d;
      rem_re_q <= rem_re_d;
      rem_im_q <= rem_im_d;
      quo_re_q <= quo_re_d;
      quo_im_q <= quo_im_d;
      den_q    <= den_d;
      sgn_re_q <= sgn_re_d;
      sgn_im_q <= sgn_im_d;
      ov_re_q  <= ov_re_d;
      ov_im_q  <= ov_im_d;
      zero_q   <= zero_d;
      i_q      <= i_d;
      q_q      <= q_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign busy = state_q != IDLE;
  assign done = done_q;
  assign I    = i_q;
  assign Q    = q_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule
